// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the MIPS pipeline controller: opcodes, functs, ALU codes,
// control-word layout and literal words, PC/forwarding selects and sequencer states.
package pipe_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam int CW_MEMREAD  = 8;
    localparam int CW_MEMWRITE = 7;
    localparam int CW_ALUSRC   = 6;
    localparam int CW_REGDST   = 5;
    localparam int CW_ALUOP_LO = 2;
    localparam int CW_MEMTOREG = 1;
    localparam int CW_REGWRITE = 0;

    localparam logic [8:0] CW_NONE       = 9'h000;
    localparam logic [8:0] CW_RTYPE_BASE = 9'h001;
    localparam logic [8:0] CW_LW         = 9'h16B;
    localparam logic [8:0] CW_SW         = 9'h0C8;
    localparam logic [8:0] CW_ADDI       = 9'h069;

    localparam logic [1:0] PC_SEQ    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam logic [1:0] FWD_IDEX  = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_WB    = 2'b10;

    typedef enum logic [1:0] {BOOT, RUN, HALT} seq_state_t;

    function automatic logic [8:0] rtype_word(input logic [2:0] aluop);
        return CW_RTYPE_BASE | {4'b0000, aluop, 2'b00};
    endfunction

endpackage

// File: rtl/mips_main_decoder.sv
// Main decoder: opcode/funct to 9-bit control word plus branch/jump class flags.
// Purely combinational; unknown encodings give an all-zero word.
module mips_main_decoder
    import pipe_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [8:0] ctrl,
    output logic       is_branch,
    output logic       is_bne,
    output logic       is_jump,
    output logic       uses_rt
);

    always_comb begin
        ctrl      = CW_NONE;
        is_branch = 1'b0;
        is_bne    = 1'b0;
        is_jump   = 1'b0;
        uses_rt   = 1'b1;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  ctrl = rtype_word(ALU_ADD);
                    FN_SUB:  ctrl = rtype_word(ALU_SUB);
                    FN_AND:  ctrl = rtype_word(ALU_AND);
                    FN_OR:   ctrl = rtype_word(ALU_OR);
                    FN_SLT:  ctrl = rtype_word(ALU_SLT);
                    default: ctrl = CW_NONE;
                endcase
            end
            OP_LW:   ctrl = CW_LW;
            OP_SW:   ctrl = CW_SW;
            OP_ADDI: ctrl = CW_ADDI;
            OP_BEQ:  is_branch = 1'b1;
            OP_BNE: begin
                is_branch = 1'b1;
                is_bne    = 1'b1;
            end
            // a jump carries a target, not register fields, so it never creates a hazard
            OP_J: begin
                is_jump = 1'b1;
                uses_rt = 1'b0;
            end
            default: ctrl = CW_NONE;
        endcase
    end

endmodule

// File: rtl/pipeline_sequencer.sv
// Central controller for the 5-stage MIPS datapath: decode, hazard stalls, forwarding,
// branch/jump redirect with IF/ID flush, and a boot-hold / debug-halt sequencer.
module pipeline_sequencer
    import pipe_ctrl_pkg::*;
#(
    parameter int BOOT_CYCLES = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instruction,
    input  logic [4:0]       RSReg,
    input  logic [4:0]       RTReg,
    input  logic [4:0]       RDReg,
    input  logic [4:0]       RDRegStage4,
    input  logic [4:0]       RDRegStage5,
    input  logic             WriteRegSignalStage4,
    input  logic             WriteRegSignalStage5,
    input  logic             MemReadNextStage,
    input  logic             EorEbar,
    input  logic             halt_req,
    output logic [8:0]       ControlOutput,
    output logic             HazardSel,
    output logic             PCWrite,
    output logic             IF_IdWrite,
    output logic             aclr,
    output logic [1:0]       PCSrc,
    output logic [1:0]       ForwardingWire3,
    output logic [1:0]       ForwardingWire4,
    output logic             halted,
    output logic [CNT_W-1:0] stall_count
);

    localparam int BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES + 1) : 1;

    seq_state_t       state, state_nxt;
    logic [BW-1:0]    boot_cnt;
    logic [8:0]       ex_ctrl;
    logic             mem_memread;
    logic             flush;
    logic [CNT_W-1:0] cnt;

    logic       is_branch, is_bne, is_jump, uses_rt;
    logic [4:0] id_rs, id_rt, ex_dst;
    logic       load_use, branch_stall, hazard, taken;
    logic       stall, redirect;
    logic       unused_imm;

    assign id_rs      = instruction[25:21];
    assign id_rt      = instruction[20:16];
    assign unused_imm = ^instruction[15:6];

    mips_main_decoder u_dec (
        .opcode    (instruction[31:26]),
        .funct     (instruction[5:0]),
        .ctrl      (ControlOutput),
        .is_branch (is_branch),
        .is_bne    (is_bne),
        .is_jump   (is_jump),
        .uses_rt   (uses_rt)
    );

    function automatic logic hits(input logic [4:0] r, input logic [4:0] a, input logic [4:0] b);
        return (r != 5'd0) && ((r == a) || (r == b));
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [4:0] src, input logic we4, input logic [4:0] rd4,
                                           input logic we5, input logic [4:0] rd5);
        if (we4 && rd4 != 5'd0 && rd4 == src)      return FWD_EXMEM;
        else if (we5 && rd5 != 5'd0 && rd5 == src) return FWD_WB;
        else                                       return FWD_IDEX;
    endfunction

    assign ForwardingWire3 = fwd_sel(RSReg, WriteRegSignalStage4, RDRegStage4, WriteRegSignalStage5, RDRegStage5);
    assign ForwardingWire4 = fwd_sel(RTReg, WriteRegSignalStage4, RDRegStage4, WriteRegSignalStage5, RDRegStage5);

    assign ex_dst   = ex_ctrl[CW_REGDST] ? RTReg : RDReg;
    assign load_use = MemReadNextStage && !is_jump && hits(RTReg, id_rs, uses_rt ? id_rt : id_rs);
    // a load sitting in MEM is a pending write even before its RegWrite status reaches us
    assign branch_stall = is_branch &&
        ((ex_ctrl[CW_REGWRITE] && hits(ex_dst, id_rs, id_rt)) ||
         ((WriteRegSignalStage4 || mem_memread) && hits(RDRegStage4, id_rs, id_rt)) ||
         (WriteRegSignalStage5 && hits(RDRegStage5, id_rs, id_rt)));
    assign hazard = load_use || branch_stall;
    assign taken  = is_branch && (is_bne ? !EorEbar : EorEbar);

    always_comb begin
        state_nxt  = state;
        PCWrite    = 1'b0;
        IF_IdWrite = 1'b0;
        HazardSel  = 1'b0;
        PCSrc      = PC_SEQ;
        stall      = 1'b0;
        redirect   = 1'b0;
        case (state)
            BOOT: begin
                if (boot_cnt >= BW'(BOOT_CYCLES - 1)) state_nxt = RUN;
            end
            RUN: begin
                if (hazard) begin
                    stall = 1'b1;
                end else begin
                    PCWrite    = 1'b1;
                    IF_IdWrite = 1'b1;
                    HazardSel  = 1'b1;
                    if (taken) begin
                        PCSrc    = PC_BRANCH;
                        redirect = 1'b1;
                    end else if (is_jump) begin
                        PCSrc    = PC_JUMP;
                        redirect = 1'b1;
                    end
                end
                // halting on a redirect would lose the flush of the wrong-path fetch
                if (halt_req && !redirect) state_nxt = HALT;
            end
            HALT: begin
                if (!halt_req) state_nxt = RUN;
            end
            default: state_nxt = BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= BOOT;
            boot_cnt    <= '0;
            ex_ctrl     <= CW_NONE;
            mem_memread <= 1'b0;
            flush       <= 1'b0;
            cnt         <= '0;
        end else begin
            state       <= state_nxt;
            boot_cnt    <= (state == BOOT) ? boot_cnt + 1'b1 : '0;
            ex_ctrl     <= HazardSel ? ControlOutput : CW_NONE;
            mem_memread <= ex_ctrl[CW_MEMREAD];
            flush       <= redirect;
            if (stall && cnt != {CNT_W{1'b1}}) cnt <= cnt + 1'b1;
        end
    end

    assign aclr        = flush;
    assign halted      = (state == HALT);
    assign stall_count = cnt;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed test-plan scenarios followed by randomized traffic, all checked against a
// cycle-level reference model of the sequencer's rules.
module tb_pipeline_sequencer;

    logic        clk;
    logic        rst;
    logic [31:0] instruction;
    logic [4:0]  RSReg, RTReg, RDReg, RDRegStage4, RDRegStage5;
    logic        WriteRegSignalStage4, WriteRegSignalStage5, MemReadNextStage, EorEbar, halt_req;
    logic [8:0]  ControlOutput;
    logic        HazardSel, PCWrite, IF_IdWrite, aclr, halted;
    logic [1:0]  PCSrc, ForwardingWire3, ForwardingWire4;
    logic [15:0] stall_count;

    int checks = 0;
    int errors = 0;

    // reference model state
    int         m_boot_left;
    bit         m_halted, m_flush;
    int         m_count;
    logic [8:0] m_ex_word, m_mem_word;
    bit         m_stall, m_en, m_redirect;
    logic [8:0] m_word;

    pipeline_sequencer #(.BOOT_CYCLES(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .instruction(instruction),
        .RSReg(RSReg), .RTReg(RTReg), .RDReg(RDReg),
        .RDRegStage4(RDRegStage4), .RDRegStage5(RDRegStage5),
        .WriteRegSignalStage4(WriteRegSignalStage4), .WriteRegSignalStage5(WriteRegSignalStage5),
        .MemReadNextStage(MemReadNextStage), .EorEbar(EorEbar), .halt_req(halt_req),
        .ControlOutput(ControlOutput), .HazardSel(HazardSel), .PCWrite(PCWrite),
        .IF_IdWrite(IF_IdWrite), .aclr(aclr), .PCSrc(PCSrc),
        .ForwardingWire3(ForwardingWire3), .ForwardingWire4(ForwardingWire4),
        .halted(halted), .stall_count(stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [8:0] ref_decode(input logic [31:0] i);
        logic [5:0] op, fn;
        op = i[31:26];
        fn = i[5:0];
        if (op == 6'h00) begin
            case (fn)
                6'h20:   return 9'h009;
                6'h22:   return 9'h019;
                6'h24:   return 9'h001;
                6'h25:   return 9'h005;
                6'h2A:   return 9'h01D;
                default: return 9'h000;
            endcase
        end
        case (op)
            6'h23:   return 9'h16B;
            6'h2B:   return 9'h0C8;
            6'h08:   return 9'h069;
            default: return 9'h000;
        endcase
    endfunction

    function automatic bit dep(input logic [4:0] r, input logic [4:0] a, input logic [4:0] b);
        return (r != 0) && (r == a || r == b);
    endfunction

    function automatic logic [1:0] ref_fwd(input logic [4:0] src);
        if (WriteRegSignalStage4 && RDRegStage4 != 0 && RDRegStage4 == src) return 2'd1;
        if (WriteRegSignalStage5 && RDRegStage5 != 0 && RDRegStage5 == src) return 2'd2;
        return 2'd0;
    endfunction

    task automatic model_reset();
        m_boot_left = 2;
        m_halted    = 0;
        m_flush     = 0;
        m_count     = 0;
        m_ex_word   = 0;
        m_mem_word  = 0;
    endtask

    // evaluate the model against the DUT for the current inputs (called away from the edge)
    task automatic eval();
        logic [4:0] rs, rt, ex_dst;
        logic [5:0] op;
        bit jump, beq, bne, lu, bs, running;
        logic [1:0] pcs;
        #1;
        op      = instruction[31:26];
        rs      = instruction[25:21];
        rt      = instruction[20:16];
        jump    = (op == 6'h02);
        beq     = (op == 6'h04);
        bne     = (op == 6'h05);
        m_word  = ref_decode(instruction);
        ex_dst  = m_ex_word[5] ? RTReg : RDReg;
        lu      = MemReadNextStage && RTReg != 0 && !jump && (RTReg == rs || RTReg == rt);
        bs      = (beq || bne) && ((m_ex_word[0] && dep(ex_dst, rs, rt)) ||
                  ((WriteRegSignalStage4 || m_mem_word[8]) && dep(RDRegStage4, rs, rt)) ||
                  (WriteRegSignalStage5 && dep(RDRegStage5, rs, rt)));
        running    = (m_boot_left == 0) && !m_halted;
        m_stall    = running && (lu || bs);
        m_en       = running && !m_stall;
        m_redirect = m_en && ((beq && EorEbar) || (bne && !EorEbar) || jump);
        pcs        = !m_redirect ? 2'd0 : (jump ? 2'd2 : 2'd1);
        check("ctrl",   ControlOutput,   m_word);
        check("hsel",   HazardSel,       m_en);
        check("pcw",    PCWrite,         m_en);
        check("ifw",    IF_IdWrite,      m_en);
        check("pcsrc",  PCSrc,           pcs);
        check("aclr",   aclr,            m_flush);
        check("fw3",    ForwardingWire3, ref_fwd(RSReg));
        check("fw4",    ForwardingWire4, ref_fwd(RTReg));
        check("halted", halted,          m_halted);
        check("scnt",   stall_count,     m_count);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (m_stall && m_count < 65535) m_count++;
            m_mem_word = m_ex_word;
            m_ex_word  = m_en ? m_word : 9'h000;
            m_flush    = m_redirect;
            if (m_boot_left > 0)               m_boot_left--;
            else if (m_halted)                 m_halted = halt_req;
            else if (halt_req && !m_redirect)  m_halted = 1;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 0; instruction = 32'h0;
        RSReg = 0; RTReg = 0; RDReg = 0; RDRegStage4 = 0; RDRegStage5 = 0;
        WriteRegSignalStage4 = 0; WriteRegSignalStage5 = 0;
        MemReadNextStage = 0; EorEbar = 0; halt_req = 0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0] fn_tab [6];
        logic [5:0] op;
        logic [4:0] rs, rt, rd;
        fn_tab = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00};
        rs = 5'($urandom_range(0, 3));
        rt = 5'($urandom_range(0, 3));
        rd = 5'($urandom_range(0, 3));
        case ($urandom_range(0, 10))
            0, 1, 2: begin
                fn_tab[5] = 6'($urandom);
                return {6'h00, rs, rt, rd, 5'd0, fn_tab[$urandom_range(0, 5)]};
            end
            3: op = 6'h23;
            4: op = 6'h2B;
            5: op = 6'h08;
            6: op = 6'h04;
            7: op = 6'h05;
            8: return {6'h02, 26'($urandom)};
            9: return 32'h0;
            default: op = 6'($urandom);
        endcase
        return {op, rs, rt, 16'($urandom)};
    endfunction

    initial begin
        idle();
        rst = 1;
        @(posedge clk);
        model_reset();
        @(negedge clk);

        // reset and boot hold
        eval(); tick();
        rst = 0; instruction = 32'h8C220004;
        eval(); check("boot_c0", PCWrite, 0); check("lw_word", ControlOutput, 9'h16B); tick();
        eval(); check("boot_c1", IF_IdWrite, 0); tick();
        eval(); check("boot_run", PCWrite, 1); tick();

        // load-use: one stall cycle
        instruction = 32'h00441820; MemReadNextStage = 1; RTReg = 2;
        eval(); check("lu_pcw", PCWrite, 0); check("lu_hsel", HazardSel, 0); tick();
        MemReadNextStage = 0;
        eval(); check("lu_cnt", stall_count, 1); check("lu_resume", PCWrite, 1); tick();

        // forwarding priority and $zero
        idle(); RSReg = 5; RDRegStage4 = 5; WriteRegSignalStage4 = 1; RDRegStage5 = 5; WriteRegSignalStage5 = 1;
        eval(); check("fwd_prio", ForwardingWire3, 2'b01); tick();
        idle(); WriteRegSignalStage4 = 1;
        eval(); check("fwd_zero", ForwardingWire4, 2'b00); tick();

        // taken beq, then untaken bne
        idle(); instruction = 32'h10220003; EorEbar = 1;
        eval(); check("beq_pcsrc", PCSrc, 2'b01); check("beq_aclr_now", aclr, 0); tick();
        idle();
        eval(); check("beq_aclr1", aclr, 1); tick();
        eval(); check("beq_aclr0", aclr, 0); tick();
        instruction = 32'h14220003; EorEbar = 1;
        eval(); check("bne_pcsrc", PCSrc, 2'b00); tick();
        idle();
        eval(); check("bne_noaclr", aclr, 0); tick();

        // plain halt enters after one cycle
        halt_req = 1;
        eval(); tick();
        halt_req = 0;
        eval(); check("halt_fast", halted, 1); check("halt_pcw", PCWrite, 0); tick();
        eval(); check("halt_exit", halted, 0); tick();

        // jump with halt: halt entry deferred by the redirect
        instruction = 32'h08000010; halt_req = 1;
        eval(); check("j_pcsrc", PCSrc, 2'b10); tick();
        instruction = 32'h0;
        eval(); check("j_aclr", aclr, 1); check("j_defer", halted, 0); tick();
        eval(); check("j_halted", halted, 1); tick();

        // reset during halt
        rst = 1;
        eval(); tick();
        idle();
        eval();
        check("rst_halted", halted, 0); check("rst_pcw", PCWrite, 0);
        check("rst_aclr", aclr, 0); check("rst_cnt", stall_count, 0);
        tick();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst                  = ($urandom_range(0, 99) == 0);
            instruction          = rand_instr();
            RSReg                = 5'($urandom_range(0, 3));
            RTReg                = 5'($urandom_range(0, 3));
            RDReg                = 5'($urandom_range(0, 3));
            RDRegStage4          = 5'($urandom_range(0, 3));
            RDRegStage5          = 5'($urandom_range(0, 3));
            WriteRegSignalStage4 = 1'($urandom);
            WriteRegSignalStage5 = 1'($urandom);
            MemReadNextStage     = ($urandom_range(0, 3) == 0);
            EorEbar              = 1'($urandom);
            halt_req             = ($urandom_range(0, 7) == 0);
            eval();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_sequencer.md
# pipeline_sequencer

Central controller for the 5-stage MIPS datapath. It decodes the IF/ID instruction into the 9-bit control word and performs hazard detection (load-use and branch-operand stalls). It also drives EX-stage forwarding selects and branch/jump redirection with IF/ID flush. A small FSM adds a post-reset boot hold and a debug halt. The block sits beside the datapath and drives all of the datapath's control inputs from the datapath's status outputs.

## Interface
Parameters:
- BOOT_CYCLES, 2: cycles PC and IF/ID stay frozen after reset release, so instruction and data memories can finish loading.
- CNT_W, 16: width of the stall counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- instruction  in  32  IF/ID instruction.
- RSReg, RTReg, RDReg  in  5 each  ID/EX register fields.
- RDRegStage4, RDRegStage5  in  5 each  destination register in EX/MEM and in MEM/WB.
- WriteRegSignalStage4, WriteRegSignalStage5  in  1 each  RegWrite in EX/MEM and in MEM/WB.
- MemReadNextStage  in  1  ID/EX MemRead.
- EorEbar  in  1  ID-stage rs==rt comparator.
- halt_req  in  1  debug halt request.
- ControlOutput  out  9  {MemRead, MemWrite, ALUSrc, RegDst, ALUop[2:0], MemtoReg, RegWrite}, bit 8 down to 0. RegDst=1 selects rt.
- HazardSel  out  1  1 passes ControlOutput into ID/EX; 0 inserts a bubble.
- PCWrite, IF_IdWrite  out  1 each  load enables.
- aclr  out  1  IF/ID flush pulse.
- PCSrc  out  2  00 PC+4, 01 branch target, 10 jump.
- ForwardingWire3, ForwardingWire4  out  2 each  ALU A/B select: 00 ID/EX, 01 EX/MEM, 10 WB.
- halted  out  1  FSM in HALT.
- stall_count  out  CNT_W  load-use plus branch stall cycles since reset.

## Operation
- Decode (from instruction; unknown opcode/funct gives 0):
  - R-type (opcode 0): add=0x009, sub=0x019, and=0x001, or=0x005, slt=0x01D. Funct→ALUop: 100000→010, 100010→110, 100100→000, 100101→001, 101010→111.
  - lw 100011→0x16B; sw 101011→0x0C8; addi 001000→0x069.
  - beq 000100, bne 000101, j 000010, and all-zero instruction → 0.
- Shadow pipeline: registers hold the issued control word (post-HazardSel) for EX and MEM. This gives EX RegWrite, EX destination (RegDst ? RTReg : RDReg) and MEM MemRead.
- Forwarding (A uses RSReg, B uses RTReg):
  - 01 if WriteRegSignalStage4, RDRegStage4≠0 and RDRegStage4 matches the source.
  - Otherwise 10 if the same conditions hold for stage 5.
  - Otherwise 00.
  - Combinational in every state.
- Load-use stall: MemReadNextStage and RTReg≠0 and RTReg ∈ {instr rs, instr rt}, for any non-j instruction.
- Branch stall: beq/bne in ID while any pending non-zero write (EX shadow, stage 4, or stage 5) targets instr rs or rt.
- Stall action: PCWrite=0, IF_IdWrite=0, HazardSel=0, PCSrc=00, stall_count+1 (saturating).
- Redirect when not stalled:
  - Taken branch = (beq & EorEbar) | (bne & ~EorEbar) → PCSrc=01.
  - j → PCSrc=10.
  - In both cases the flush flag is set, and aclr=1 for exactly the following cycle.
- FSM:
  - BOOT: PCWrite=IF_IdWrite=HazardSel=0. Counts BOOT_CYCLES, then goes to RUN.
  - RUN: normal operation. halt_req=1 → HALT, except in a redirect cycle, where entry is deferred one cycle.
  - HALT: PCWrite=IF_IdWrite=HazardSel=0, so the pipeline drains bubbles. halt_req=0 → RUN.
- rst in any state (including mid-stall, mid-flush or HALT) → BOOT next edge and clears shadow registers, flush flag and counters.

## Timing
- Reset values: state BOOT; PCWrite, IF_IdWrite, HazardSel, aclr, halted = 0; PCSrc, forwarding = 00; stall_count = 0. ControlOutput is combinational from instruction.
- Hazard, forwarding, PCSrc and enables: combinational, zero latency.
- aclr, halted and stall_count: registered, one-cycle latency.
- Load-use: exactly one stall cycle. Branch: stalls until the pending writes clear.
- Stall and redirect in the same cycle: stall wins and the redirect is re-evaluated next cycle.

## Structure
- Package pipe_ctrl_pkg: opcode and funct constants, ALUop codes, control-word bit positions and literal words, PCSrc and forwarding encodings, state enum {BOOT, RUN, HALT}.
- Sub-module mips_main_decoder: combinational, instruction→9-bit word plus is_branch, is_bne, is_jump, uses_rt.
- Everything else lives in pipeline_sequencer.

## Test plan
- Reset boot: rst 2 cycles then release → enables 0 for 2 cycles, then 1. instruction 0x8C220004 (lw) → ControlOutput=0x16B.
- Load-use: MemReadNextStage=1, RTReg=2, instruction 0x00441820 (add $3,$2,$4) → one cycle with PCWrite=IF_IdWrite=HazardSel=0; stall_count=1.
- Forwarding priority: RSReg=5 with stage4 RD=5/WE=1 and stage5 RD=5/WE=1 → ForwardingWire3=01. RTReg=0 with stage4 RD=0/WE=1 → ForwardingWire4=00.
- Branch: 0x10220003 (beq $1,$2) with EorEbar=1, no pending writes → PCSrc=01, aclr=1 next cycle only. bne 0x14220003 with EorEbar=1 → PCSrc=00, no aclr.
- Jump with halt: 0x08000010 and halt_req=1 in the same cycle → PCSrc=10, aclr next cycle, halted one cycle later than a non-redirect halt.
- Reset mid-halt: rst during HALT → next cycle BOOT, all outputs at reset values, stall_count=0.
